// File: rtl/gtf_link_reset_mgr_if.sv
// ----------------------------------------------------------------------------
// gtf_link_reset_mgr_if
//   Signal bundle between the GTF link reset manager and its surroundings.
//   Everything is synchronous to gtf_freerun_clk, which is a plain port of the
//   manager and is not carried here.
//
// Handshake semantics: there is no valid/ready pairing on this bundle. Level
//   inputs (clk_wiz_locked_in, link_status_in) are sampled every cycle.
//   Pulse inputs (user_reset_req_in, link_down_clr_in) act in each cycle they
//   are high. All outputs are registered levels that are valid every cycle.
//
// Signals
//   clk_wiz_locked_in     clock wizard lock, already synchronised
//   user_reset_req_in     single-cycle request to restart the global sequence
//   link_status_in        per-channel link-up status
//   link_down_clr_in      per-channel clear of the down latch and counter
//   gtwiz_reset_all_out   active-high global wizard reset
//   ch_reset_out          active-high per-channel retry reset
//   link_stable_out       channel qualified stable
//   link_down_latched_out sticky: a stable link was lost
//   link_down_count_out   saturating link-loss counts, channel i at [i*CNT_W +: CNT_W]
//   g_state_dbg           global FSM state
//   ch_state_dbg          channel FSM states, channel i at [i*3 +: 3]
//
// Modports
//   master  drives the inputs of the manager (surrounding logic / bench)
//   slave   the manager itself
// ----------------------------------------------------------------------------
interface gtf_link_reset_mgr_if #(
  parameter int NUM_CHANNEL = 4,
  parameter int CNT_W       = 16
);
  logic                         clk_wiz_locked_in;
  logic                         user_reset_req_in;
  logic [NUM_CHANNEL-1:0]       link_status_in;
  logic [NUM_CHANNEL-1:0]       link_down_clr_in;
  logic                         gtwiz_reset_all_out;
  logic [NUM_CHANNEL-1:0]       ch_reset_out;
  logic [NUM_CHANNEL-1:0]       link_stable_out;
  logic [NUM_CHANNEL-1:0]       link_down_latched_out;
  logic [NUM_CHANNEL*CNT_W-1:0] link_down_count_out;
  logic [1:0]                   g_state_dbg;
  logic [NUM_CHANNEL*3-1:0]     ch_state_dbg;

  modport master (
    output clk_wiz_locked_in, user_reset_req_in, link_status_in, link_down_clr_in,
    input  gtwiz_reset_all_out, ch_reset_out, link_stable_out,
           link_down_latched_out, link_down_count_out, g_state_dbg, ch_state_dbg
  );

  modport slave (
    input  clk_wiz_locked_in, user_reset_req_in, link_status_in, link_down_clr_in,
    output gtwiz_reset_all_out, ch_reset_out, link_stable_out,
           link_down_latched_out, link_down_count_out, g_state_dbg, ch_state_dbg
  );
endinterface

// File: rtl/gtf_link_reset_mgr.sv
// ----------------------------------------------------------------------------
// gtf_link_reset_mgr
//   Reset sequencer and link-stability supervisor for the GTF channels.
//   A global FSM holds gtwiz_reset_all_out until the clock wizard is locked
//   and RESET_DELAY cycles have passed. Per-channel FSMs then qualify each
//   link as stable after STABLE_CYCLES consecutive up samples, and latch and
//   count losses of a stable link.
//
// Build option
//   GTF_LINK_AUTO_RETRY_EN  when defined, a channel that waits LINK_TIMEOUT
//                           cycles for link-up gets a RETRY_PULSE-cycle
//                           ch_reset_out pulse. When undefined the retry state
//                           and timeout counter are absent and ch_reset_out=0.
//
// Ports
//   gtf_freerun_clk   sole clock
//   gtf_freerun_rst   synchronous active-high reset
//   bus               gtf_link_reset_mgr_if.slave (all other I/O)
// ----------------------------------------------------------------------------
module gtf_link_reset_mgr #(
  parameter int NUM_CHANNEL   = 4,
  parameter int RESET_DELAY   = 100,
  parameter int STABLE_CYCLES = 2048,
  parameter int LINK_TIMEOUT  = 1000000,
  parameter int RETRY_PULSE   = 16,
  parameter int CNT_W         = 16
) (
  input  logic                gtf_freerun_clk,
  input  logic                gtf_freerun_rst,
  gtf_link_reset_mgr_if.slave bus
);

  if (RESET_DELAY < 1 || STABLE_CYCLES < 1 || LINK_TIMEOUT < 1 ||
      RETRY_PULSE < 1 || CNT_W < 1 || NUM_CHANNEL < 1) begin : g_param_check
    $error("gtf_link_reset_mgr: parameter out of range");
  end

  localparam logic [1:0] G_WAIT_LOCK = 2'd0;
  localparam logic [1:0] G_DELAY     = 2'd1;
  localparam logic [1:0] G_RUN       = 2'd2;

  localparam logic [2:0] C_IDLE    = 3'd0;
  localparam logic [2:0] C_WAIT_UP = 3'd1;
  localparam logic [2:0] C_QUALIFY = 3'd2;
  localparam logic [2:0] C_STABLE  = 3'd3;
`ifdef GTF_LINK_AUTO_RETRY_EN
  localparam logic [2:0] C_RESET   = 3'd4;
  localparam int TW = $clog2(LINK_TIMEOUT + 1);
  localparam int PW = $clog2(RETRY_PULSE + 1);
`endif

  localparam int DW = $clog2(RESET_DELAY + 1);
  localparam int QW = $clog2(STABLE_CYCLES + 1);

  // Global sequencer
  logic [1:0]    g_state, g_next;
  logic [DW-1:0] dly_q, dly_next;
  logic          gtwiz_q;

  // Per-channel supervisors
  logic [2:0]             c_state   [NUM_CHANNEL];
  logic [2:0]             c_next    [NUM_CHANNEL];
  logic [QW-1:0]          qual_q    [NUM_CHANNEL];
  logic [QW-1:0]          qual_next [NUM_CHANNEL];
  logic [NUM_CHANNEL-1:0] down_evt;
  logic [NUM_CHANNEL-1:0] stable_q;
  logic [NUM_CHANNEL-1:0] latch_q;
  logic [NUM_CHANNEL*CNT_W-1:0] cnt_q;
  logic [NUM_CHANNEL*3-1:0]     ch_dbg;
`ifdef GTF_LINK_AUTO_RETRY_EN
  logic [TW-1:0]          to_q    [NUM_CHANNEL];
  logic [TW-1:0]          to_next [NUM_CHANNEL];
  logic [PW-1:0]          rp_q    [NUM_CHANNEL];
  logic [PW-1:0]          rp_next [NUM_CHANNEL];
  logic [NUM_CHANNEL-1:0] chrst_q;
`endif

  // Lock loss is checked first so it beats a coincident user request.
  // The counter transitions on reaching 1 so that the release lands exactly
  // RESET_DELAY+1 cycles after lock is first seen.
  always_comb begin
    g_next   = g_state;
    dly_next = dly_q;
    if (!bus.clk_wiz_locked_in) begin
      g_next = G_WAIT_LOCK;
    end else begin
      case (g_state)
        G_WAIT_LOCK: begin
          g_next   = G_DELAY;
          dly_next = DW'(RESET_DELAY);
        end
        G_DELAY: begin
          if (bus.user_reset_req_in) begin
            dly_next = DW'(RESET_DELAY);
          end else if (dly_q == DW'(1)) begin
            g_next   = G_RUN;
            dly_next = '0;
          end else begin
            dly_next = dly_q - DW'(1);
          end
        end
        G_RUN: begin
          if (bus.user_reset_req_in) begin
            g_next   = G_DELAY;
            dly_next = DW'(RESET_DELAY);
          end
        end
        default: g_next = G_WAIT_LOCK;
      endcase
    end
  end

  // Channels follow g_next so that they enter C_WAIT_UP in the same cycle
  // the global FSM enters G_RUN, and drop to C_IDLE in the same cycle it
  // leaves. A forced drop is never a link-down event.
  always_comb begin
    for (int i = 0; i < NUM_CHANNEL; i++) begin
      c_next[i]    = c_state[i];
      qual_next[i] = qual_q[i];
      down_evt[i]  = 1'b0;
`ifdef GTF_LINK_AUTO_RETRY_EN
      to_next[i]   = to_q[i];
      rp_next[i]   = rp_q[i];
`endif
      if (g_next != G_RUN) begin
        c_next[i]    = C_IDLE;
        qual_next[i] = '0;
`ifdef GTF_LINK_AUTO_RETRY_EN
        to_next[i]   = '0;
        rp_next[i]   = '0;
`endif
      end else begin
        case (c_state[i])
          C_IDLE: begin
            c_next[i]    = C_WAIT_UP;
            qual_next[i] = '0;
`ifdef GTF_LINK_AUTO_RETRY_EN
            to_next[i]   = '0;
`endif
          end
          C_WAIT_UP: begin
            if (bus.link_status_in[i]) begin
              if (STABLE_CYCLES == 1) begin
                c_next[i] = C_STABLE;
              end else begin
                c_next[i]    = C_QUALIFY;
                qual_next[i] = QW'(1);
              end
`ifdef GTF_LINK_AUTO_RETRY_EN
            end else if (to_q[i] == TW'(LINK_TIMEOUT)) begin
              c_next[i]  = C_RESET;
              rp_next[i] = '0;
            end else begin
              to_next[i] = to_q[i] + TW'(1);
`endif
            end
          end
          C_QUALIFY: begin
            if (!bus.link_status_in[i]) begin
              c_next[i]    = C_WAIT_UP;
              qual_next[i] = '0;
`ifdef GTF_LINK_AUTO_RETRY_EN
              to_next[i]   = '0;
`endif
            end else if (qual_q[i] == QW'(STABLE_CYCLES - 1)) begin
              c_next[i] = C_STABLE;
            end else begin
              qual_next[i] = qual_q[i] + QW'(1);
            end
          end
          C_STABLE: begin
            if (!bus.link_status_in[i]) begin
              c_next[i]    = C_WAIT_UP;
              qual_next[i] = '0;
              down_evt[i]  = 1'b1;
`ifdef GTF_LINK_AUTO_RETRY_EN
              to_next[i]   = '0;
`endif
            end
          end
`ifdef GTF_LINK_AUTO_RETRY_EN
          C_RESET: begin
            if (rp_q[i] == PW'(RETRY_PULSE - 1)) begin
              c_next[i]  = C_WAIT_UP;
              to_next[i] = '0;
            end else begin
              rp_next[i] = rp_q[i] + PW'(1);
            end
          end
`endif
          default: c_next[i] = C_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge gtf_freerun_clk) begin
    if (gtf_freerun_rst) begin
      g_state  <= G_WAIT_LOCK;
      dly_q    <= '0;
      gtwiz_q  <= 1'b1;
      stable_q <= '0;
      latch_q  <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < NUM_CHANNEL; i++) begin
        c_state[i] <= C_IDLE;
        qual_q[i]  <= '0;
`ifdef GTF_LINK_AUTO_RETRY_EN
        to_q[i]    <= '0;
        rp_q[i]    <= '0;
`endif
      end
`ifdef GTF_LINK_AUTO_RETRY_EN
      chrst_q <= '0;
`endif
    end else begin
      g_state <= g_next;
      dly_q   <= dly_next;
      gtwiz_q <= (g_next != G_RUN);
      for (int i = 0; i < NUM_CHANNEL; i++) begin
        c_state[i]  <= c_next[i];
        qual_q[i]   <= qual_next[i];
        stable_q[i] <= (c_next[i] == C_STABLE);
`ifdef GTF_LINK_AUTO_RETRY_EN
        to_q[i]     <= to_next[i];
        rp_q[i]     <= rp_next[i];
        chrst_q[i]  <= (c_next[i] == C_RESET);
`endif
        // A clear coinciding with a new loss leaves exactly that one loss.
        if (down_evt[i]) begin
          latch_q[i] <= 1'b1;
          if (bus.link_down_clr_in[i]) begin
            cnt_q[i*CNT_W +: CNT_W] <= CNT_W'(1);
          end else if (cnt_q[i*CNT_W +: CNT_W] != {CNT_W{1'b1}}) begin
            cnt_q[i*CNT_W +: CNT_W] <= cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
          end
        end else if (bus.link_down_clr_in[i]) begin
          latch_q[i]              <= 1'b0;
          cnt_q[i*CNT_W +: CNT_W] <= '0;
        end
      end
    end
  end

  always_comb begin
    ch_dbg = '0;
    for (int i = 0; i < NUM_CHANNEL; i++) begin
      ch_dbg[i*3 +: 3] = c_state[i];
    end
  end

  assign bus.gtwiz_reset_all_out   = gtwiz_q;
  assign bus.link_stable_out       = stable_q;
  assign bus.link_down_latched_out = latch_q;
  assign bus.link_down_count_out   = cnt_q;
  assign bus.g_state_dbg           = g_state;
  assign bus.ch_state_dbg          = ch_dbg;
`ifdef GTF_LINK_AUTO_RETRY_EN
  assign bus.ch_reset_out          = chrst_q;
`else
  assign bus.ch_reset_out          = '0;
`endif

endmodule

// File: tb/tb_gtf_link_reset_mgr.sv
// ----------------------------------------------------------------------------
// tb_gtf_link_reset_mgr
//   Directed bench for gtf_link_reset_mgr. Stimulus tasks push the output
//   value each action must produce, with the cycle it is due, onto exp_q;
//   a negedge monitor pops due entries and compares them against the DUT.
// ----------------------------------------------------------------------------
module tb_gtf_link_reset_mgr;
  localparam int NUM_CHANNEL   = 4;
  localparam int RESET_DELAY   = 100;
  localparam int STABLE_CYCLES = 2048;
  localparam int LINK_TIMEOUT  = 50;
  localparam int RETRY_PULSE   = 16;
  localparam int CNT_W         = 2;

  localparam int SEL_RST = 0;
  localparam int SEL_CHR = 1;
  localparam int SEL_STB = 2;
  localparam int SEL_LAT = 3;
  localparam int SEL_CNT = 4;

`ifdef GTF_LINK_AUTO_RETRY_EN
  localparam logic [7:0] RETRY_ON = 8'h0F;
`else
  localparam logic [7:0] RETRY_ON = 8'h00;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gtf_link_reset_mgr_if #(.NUM_CHANNEL(NUM_CHANNEL), .CNT_W(CNT_W)) bus ();

  gtf_link_reset_mgr #(
    .NUM_CHANNEL  (NUM_CHANNEL),
    .RESET_DELAY  (RESET_DELAY),
    .STABLE_CYCLES(STABLE_CYCLES),
    .LINK_TIMEOUT (LINK_TIMEOUT),
    .RETRY_PULSE  (RETRY_PULSE),
    .CNT_W        (CNT_W)
  ) dut (
    .gtf_freerun_clk(clk),
    .gtf_freerun_rst(rst),
    .bus            (bus)
  );

  // ---------------- scoreboard ----------------
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  int         exp_due_q[$];
  int         exp_sel_q[$];
  string      exp_tag_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, want);
    end
  endtask

  task automatic expect_at(input int due, input int sel, input logic [7:0] val, input string tag);
    exp_due_q.push_back(due);
    exp_sel_q.push_back(sel);
    exp_q.push_back(val);
    exp_tag_q.push_back(tag);
  endtask

  function automatic logic [7:0] observe(input int sel);
    case (sel)
      SEL_RST: return {7'd0, bus.gtwiz_reset_all_out};
      SEL_CHR: return {4'd0, bus.ch_reset_out};
      SEL_STB: return {4'd0, bus.link_stable_out};
      SEL_LAT: return {4'd0, bus.link_down_latched_out};
      default: return bus.link_down_count_out;
    endcase
  endfunction

  always @(negedge clk) begin
    int k;
    k = 0;
    while (k < exp_q.size()) begin
      if (exp_due_q[k] <= cyc) begin
        check_eq(exp_tag_q[k], {24'd0, observe(exp_sel_q[k])}, {24'd0, exp_q[k]});
        exp_q.delete(k);
        exp_due_q.delete(k);
        exp_sel_q.delete(k);
        exp_tag_q.delete(k);
      end else begin
        k++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  // Expected outputs for a single-cycle link drop on one stable channel
  // while the others stay stable.
  task automatic drop_link(input int ch, input logic clr, input logic [7:0] lat,
                           input logic [7:0] cnt, input string tag);
    int t;
    t = cyc;
    bus.link_status_in[ch]   = 1'b0;
    bus.link_down_clr_in[ch] = clr;
    expect_at(t + 1, SEL_STB, 8'h0F & ~(8'd1 << ch), {tag, "_stable"});
    expect_at(t + 1, SEL_LAT, lat, {tag, "_latch"});
    expect_at(t + 1, SEL_CNT, cnt, {tag, "_count"});
    expect_at(t + 1 + STABLE_CYCLES - 1, SEL_STB, 8'h0F & ~(8'd1 << ch), {tag, "_requal_early"});
    expect_at(t + 1 + STABLE_CYCLES, SEL_STB, 8'h0F, {tag, "_requal"});
    tick();
    bus.link_status_in[ch]   = 1'b1;
    bus.link_down_clr_in[ch] = 1'b0;
    wait_cyc(t + STABLE_CYCLES + 2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t;
    int r;
    logic [7:0] ev;
    bus.clk_wiz_locked_in = 1'b0;
    bus.user_reset_req_in = 1'b0;
    bus.link_status_in    = '0;
    bus.link_down_clr_in  = '0;

    repeat (3) tick();
    rst = 1'b0;
    t = cyc;
    expect_at(t + 1, SEL_RST, 8'h01, "rst_gtwiz");
    expect_at(t + 1, SEL_CHR, 8'h00, "rst_ch_reset");
    expect_at(t + 1, SEL_STB, 8'h00, "rst_stable");
    expect_at(t + 1, SEL_LAT, 8'h00, "rst_latch");
    expect_at(t + 1, SEL_CNT, 8'h00, "rst_count");

    // Lock at cycle 10: release at 10 + RESET_DELAY + 1 = 111.
    wait_cyc(10);
    bus.clk_wiz_locked_in = 1'b1;
    t = cyc;
    expect_at(t + RESET_DELAY,     SEL_RST, 8'h01, "lock_gtwiz_hold");
    expect_at(t + RESET_DELAY + 1, SEL_RST, 8'h00, "lock_gtwiz_release");
    expect_at(t + RESET_DELAY + 1, SEL_STB, 8'h00, "lock_stable");
    expect_at(t + RESET_DELAY + 1, SEL_CHR, 8'h00, "lock_ch_reset");
    expect_at(t + RESET_DELAY + 1, SEL_LAT, 8'h00, "lock_latch");
    expect_at(t + RESET_DELAY + 1, SEL_CNT, 8'h00, "lock_count");

    // User restart while running.
    wait_cyc(t + RESET_DELAY + 5);
    t = cyc;
    bus.user_reset_req_in = 1'b1;
    expect_at(t + 1,               SEL_RST, 8'h01, "user_gtwiz_assert");
    expect_at(t + RESET_DELAY,     SEL_RST, 8'h01, "user_gtwiz_hold");
    expect_at(t + RESET_DELAY + 1, SEL_RST, 8'h00, "user_gtwiz_release");
    tick();
    bus.user_reset_req_in = 1'b0;

    // All links up from the first cycle of G_RUN; ch0 drops at sample 2000.
    r = t + RESET_DELAY + 1;
    wait_cyc(r);
    bus.link_status_in = 4'hF;
    t = cyc;
    expect_at(t + STABLE_CYCLES - 1, SEL_STB, 8'h00, "qual_early");
    expect_at(t + STABLE_CYCLES,     SEL_STB, 8'h0E, "qual_exact");
    wait_cyc(t + 1999);
    bus.link_status_in[0] = 1'b0;
    tick();
    bus.link_status_in[0] = 1'b1;
    t = cyc;
    expect_at(t + STABLE_CYCLES - 1, SEL_STB, 8'h0E, "ch0_requal_early");
    expect_at(t + STABLE_CYCLES,     SEL_STB, 8'h0F, "ch0_requal_exact");
    wait_cyc(t + STABLE_CYCLES + 1);

    // ch1: five losses into a 2-bit counter, saturating at 3.
    for (int k = 1; k <= 5; k++) begin
      ev = 8'(((k > 3) ? 3 : k) << 2);
      drop_link(1, 1'b0, 8'h02, ev, "ch1_drop");
    end

    t = cyc;
    bus.link_down_clr_in[1] = 1'b1;
    expect_at(t + 1, SEL_LAT, 8'h00, "ch1_clr_latch");
    expect_at(t + 1, SEL_CNT, 8'h00, "ch1_clr_count");
    expect_at(t + 1, SEL_STB, 8'h0F, "ch1_clr_stable");
    tick();
    bus.link_down_clr_in[1] = 1'b0;

    // ch2: one ordinary loss, then a loss coincident with a clear.
    drop_link(2, 1'b0, 8'h04, 8'h10, "ch2_drop");
    drop_link(2, 1'b1, 8'h04, 8'h10, "ch2_clr_drop");

    // Lock loss with all stable, plus a user request that must be ignored.
    t = cyc;
    bus.clk_wiz_locked_in = 1'b0;
    bus.user_reset_req_in = 1'b1;
    bus.link_status_in    = '0;
    expect_at(t + 1,  SEL_RST, 8'h01, "lockloss_gtwiz");
    expect_at(t + 1,  SEL_STB, 8'h00, "lockloss_stable");
    expect_at(t + 1,  SEL_LAT, 8'h04, "lockloss_latch");
    expect_at(t + 1,  SEL_CNT, 8'h10, "lockloss_count");
    expect_at(t + 1,  SEL_CHR, 8'h00, "lockloss_ch_reset");
    expect_at(t + 10, SEL_RST, 8'h01, "lockloss_gtwiz_hold");
    tick();
    bus.user_reset_req_in = 1'b0;

    // Relock with links down: retry pulses (or none when not built).
    wait_cyc(t + 20);
    bus.clk_wiz_locked_in = 1'b1;
    t = cyc;
    r = t + RESET_DELAY + 1;
    expect_at(r - 1, SEL_RST, 8'h01, "relock_gtwiz_hold");
    expect_at(r,     SEL_RST, 8'h00, "relock_gtwiz_release");
    expect_at(r + LINK_TIMEOUT,                                SEL_CHR, 8'h00,   "retry_pre");
    expect_at(r + LINK_TIMEOUT + 1,                            SEL_CHR, RETRY_ON, "retry_first");
    expect_at(r + LINK_TIMEOUT + RETRY_PULSE,                  SEL_CHR, RETRY_ON, "retry_last");
    expect_at(r + LINK_TIMEOUT + RETRY_PULSE + 1,              SEL_CHR, 8'h00,   "retry_end");
    expect_at(r + 2 * LINK_TIMEOUT + RETRY_PULSE + 1,          SEL_CHR, 8'h00,   "retry_gap");
    expect_at(r + 2 * LINK_TIMEOUT + RETRY_PULSE + 2,          SEL_CHR, RETRY_ON, "retry_second");
    expect_at(r + 2 * LINK_TIMEOUT + RETRY_PULSE + 2,          SEL_STB, 8'h00,   "retry_stable");
    wait_cyc(r + 2 * LINK_TIMEOUT + 2 * RETRY_PULSE + 10);
    tick();

    check_eq("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog @cyc %0d: got timeout expected completion", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gtf_link_reset_mgr.md
# gtf_link_reset_mgr

Multi-channel reset sequencer and link-stability supervisor for the GTF transceiver subsystem. It sits between the clocking and reset logic and the GTF MAC example wrapper. It holds the wizard reset until the clock wizard is locked and a programmable delay has expired. It then qualifies each channel's link as stable after N consecutive link-up cycles, counts link-down events, and optionally issues per-channel retry resets when a link fails to come up.

## Interface
Parameters:
- NUM_CHANNEL, 4, number of GTF channels supervised
- RESET_DELAY, 100, cycles from lock to release of gtwiz_reset_all_out (≥1)
- STABLE_CYCLES, 2048, consecutive link-up samples required for stable (≥1)
- LINK_TIMEOUT, 1000000, cycles in WAIT_UP before a retry reset (auto-retry only, ≥1)
- RETRY_PULSE, 16, width of a channel retry reset in cycles (≥1)
- CNT_W, 16, width of each per-channel link-down counter

Ports:
- gtf_freerun_clk  in  1  sole clock; all I/O synchronous to it
- gtf_freerun_rst  in  1  synchronous, active-high reset
- clk_wiz_locked_in  in  1  clock wizard lock, already synchronised to gtf_freerun_clk
- user_reset_req_in  in  1  single-cycle request to restart the global sequence
- link_status_in  in  NUM_CHANNEL  per-channel link-up status, synchronous
- link_down_clr_in  in  NUM_CHANNEL  per-channel clear of latch and counter
- gtwiz_reset_all_out  out  1  active-high global wizard reset
- ch_reset_out  out  NUM_CHANNEL  active-high per-channel retry reset
- link_stable_out  out  NUM_CHANNEL  channel qualified stable
- link_down_latched_out  out  NUM_CHANNEL  sticky: stable link was lost
- link_down_count_out  out  NUM_CHANNEL*CNT_W  saturating link-loss count; channel i occupies bits [i*CNT_W +: CNT_W]

## Operation
Global FSM:
- G_WAIT_LOCK: wait for clk_wiz_locked_in=1, then go to G_DELAY with the counter loaded with RESET_DELAY.
- G_DELAY: decrement the counter; at 0, go to G_RUN.
- G_RUN: gtwiz_reset_all_out=0 in this state only.
- clk_wiz_locked_in=0 in any state forces G_WAIT_LOCK.
- user_reset_req_in in G_DELAY or G_RUN reloads the counter and enters G_DELAY.
- If lock loss and a user request occur in the same cycle, lock loss wins.

Per-channel FSM, one instance per channel:
- C_IDLE: held here while global ≠ G_RUN. Enter C_WAIT_UP the cycle G_RUN is entered.
- C_WAIT_UP: a link=1 sample goes to C_QUALIFY with qual count=1 (or directly to C_STABLE if STABLE_CYCLES=1). The timeout counter increments each cycle.
- C_QUALIFY: a link=0 sample returns to C_WAIT_UP and clears the timeout counter. When the qual count reaches STABLE_CYCLES, go to C_STABLE.
- C_STABLE: link_stable_out=1. A link=0 sample goes to C_WAIT_UP, sets the latch, and increments the count.
- C_RESET: ch_reset_out=1 for RETRY_PULSE cycles, then C_WAIT_UP with the timeout counter cleared.
- A global exit from G_RUN forces every channel to C_IDLE. This is not counted as a link-down event.

Arithmetic and boundaries:
- Qual counter width is $clog2(STABLE_CYCLES+1). Timeout counter width is $clog2(LINK_TIMEOUT+1). Neither counter wraps.
- link_down_count saturates at 2^CNT_W−1.
- If link_down_clr_in[i] and a new down event occur in the same cycle: latch=1, count=1.

## Timing
- All outputs are registered.
- Reset values: gtwiz_reset_all_out=1, ch_reset_out=0, link_stable_out=0, link_down_latched_out=0, link_down_count_out=0. Global FSM resets to G_WAIT_LOCK; channel FSMs reset to C_IDLE.
- Lock rising at cycle t: gtwiz_reset_all_out falls at t+RESET_DELAY+1.
- Link held high from the first qualifying sample at cycle t: link_stable_out rises at t+STABLE_CYCLES.
- Link falls in C_STABLE at cycle t: link_stable_out falls, the latch sets and the count increments, all at t+1.
- Lock loss at cycle t: gtwiz_reset_all_out=1 and all link_stable_out=0 at t+1.

## Configuration
- GTF_LINK_AUTO_RETRY_EN defined: the C_RESET path is active. A channel that stays in C_WAIT_UP for LINK_TIMEOUT cycles enters C_RESET.
- GTF_LINK_AUTO_RETRY_EN undefined:
  - The C_RESET state and timeout counter are not built.
  - ch_reset_out is tied to 0.
  - C_WAIT_UP waits indefinitely.
  - LINK_TIMEOUT and RETRY_PULSE are ignored.

## Test plan
- Reset, then raise lock at cycle 10 with RESET_DELAY=100 -> gtwiz_reset_all_out falls at cycle 111 and all other outputs remain 0.
- STABLE_CYCLES=2048, ch0 link high continuously -> link_stable_out[0] rises exactly 2048 cycles after the first high sample. A single-cycle drop at sample 2000 restarts qualification.
- Stable ch1, drop the link 3 times with CNT_W=2, then 2 more times -> count reads 3, then stays 3 (saturated); latch stays 1. Pulse link_down_clr_in[1] -> latch 0, count 0.
- link_down_clr_in[2] coincident with a down event -> latch=1, count=1.
- With GTF_LINK_AUTO_RETRY_EN, LINK_TIMEOUT=50, RETRY_PULSE=16, link low -> ch_reset_out pulses for 16 cycles every 67 cycles. Without the macro -> ch_reset_out is always 0.
- Drop lock while all channels are stable -> next cycle gtwiz_reset_all_out=1, link_stable_out=0 on all channels, counts unchanged. A user_reset_req_in in the same cycle is ignored.
